// File: rtl/gb_timer.sv
// rtl/gb_timer.sv - Game Boy DIV/TIMA/TMA/TAC timer bus responder
//
// Purpose: decodes the four timer registers on the CPU bus, answers reads with
// registered data, commits writes on the first edge of a low wr_n phase, runs
// the 16-bit divider and TIMA counter, and pulses irq_timer on TIMA reload.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   addr       CPU address bus
//   data_in    CPU write data
//   data_out   registered read data (8'hFF when not reading this block)
//   rd_n       CPU read strobe, active-low
//   wr_n       CPU write strobe, active-low
//   sel        combinational window decode, BASE_ADDR..BASE_ADDR+3
//   irq_timer  one-clk pulse when TIMA reloads from TMA

module gb_timer #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF04,
  parameter int unsigned CLK_PER_TICK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        rd_n,
  input  logic        wr_n,
  output logic        sel,
  output logic        irq_timer
);

  localparam logic [7:0] PRESC_MAX = 8'(CLK_PER_TICK - 1);

  localparam logic [1:0] REG_DIV  = 2'd0;
  localparam logic [1:0] REG_TIMA = 2'd1;
  localparam logic [1:0] REG_TMA  = 2'd2;
  localparam logic [1:0] REG_TAC  = 2'd3;

  logic [7:0]  presc_q, presc_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic        reload_pend_q, reload_pend_d;
  logic        tbit_q;
  logic        wr_n_q;
  logic [7:0]  data_out_q, data_out_d;
  logic        irq_q, irq_d;

  logic [15:0] offset;
  logic [1:0]  reg_idx;
  logic        tick;
  logic        div_bit;
  logic        tbit;
  logic        tbit_fall;
  logic        wr_fire;
  logic        wr_div, wr_tima, wr_tma, wr_tac;

  // Window decode by subtraction so any BASE_ADDR alignment works.
  assign offset  = addr - BASE_ADDR;
  assign sel     = (offset[15:2] == 14'd0);
  assign reg_idx = offset[1:0];

  assign tick = (presc_q == PRESC_MAX);

  // Only the first rising edge of a low wr_n phase commits.
  assign wr_fire = ~wr_n & wr_n_q & sel;
  assign wr_div  = wr_fire & (reg_idx == REG_DIV);
  assign wr_tima = wr_fire & (reg_idx == REG_TIMA);
  assign wr_tma  = wr_fire & (reg_idx == REG_TMA);
  assign wr_tac  = wr_fire & (reg_idx == REG_TAC);

  always_comb begin
    div_bit = 1'b0;
    case (tac_q[1:0])
      2'b00: div_bit = div_cnt_q[9];
      2'b01: div_bit = div_cnt_q[3];
      2'b10: div_bit = div_cnt_q[5];
      2'b11: div_bit = div_cnt_q[7];
    endcase
  end

  // Edge detect on the gated bit: clearing DIV, disabling the timer or moving
  // the select off a high bit all look like a falling edge, as on hardware.
  assign tbit      = div_bit & tac_q[2];
  assign tbit_fall = tbit_q & ~tbit;

  always_comb begin
    presc_d       = tick ? 8'd0 : presc_q + 8'd1;
    div_cnt_d     = wr_div ? 16'd0 : (tick ? div_cnt_q + 16'd1 : div_cnt_q);
    tma_d         = wr_tma ? data_in : tma_q;
    tac_d         = wr_tac ? data_in[2:0] : tac_q;
    tima_d        = tima_q;
    reload_pend_d = reload_pend_q;
    irq_d         = 1'b0;

    if (reload_pend_q && tick) begin
      // A TMA write landing on the reload tick passes straight through.
      tima_d        = tma_d;
      reload_pend_d = 1'b0;
      irq_d         = 1'b1;
    end else if (tbit_fall) begin
      tima_d = tima_q + 8'd1;
      if (tima_q == 8'hFF) begin
        reload_pend_d = 1'b1;
      end
    end

    // CPU write beats both the increment and a pending reload.
    if (wr_tima) begin
      tima_d        = data_in;
      reload_pend_d = 1'b0;
      irq_d         = 1'b0;
    end

    data_out_d = 8'hFF;
    if (!rd_n && sel) begin
      case (reg_idx)
        REG_DIV:  data_out_d = div_cnt_q[15:8];
        REG_TIMA: data_out_d = tima_q;
        REG_TMA:  data_out_d = tma_q;
        REG_TAC:  data_out_d = {5'b11111, tac_q};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= 8'd0;
      div_cnt_q     <= 16'd0;
      tima_q        <= 8'd0;
      tma_q         <= 8'd0;
      tac_q         <= 3'd0;
      reload_pend_q <= 1'b0;
      tbit_q        <= 1'b0;
      wr_n_q        <= 1'b1;
      data_out_q    <= 8'hFF;
      irq_q         <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      div_cnt_q     <= div_cnt_d;
      tima_q        <= tima_d;
      tma_q         <= tma_d;
      tac_q         <= tac_d;
      reload_pend_q <= reload_pend_d;
      tbit_q        <= tbit;
      wr_n_q        <= wr_n;
      data_out_q    <= data_out_d;
      irq_q         <= irq_d;
    end
  end

  assign data_out  = data_out_q;
  assign irq_timer = irq_q;

endmodule
